matvec_engine: RTL and testbench



---
 rtl/matvec_engine.sv | 161 ++++++++++++++++
 tb/tb_matvec_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// matvec_engine: polls the MATVEC flag, computes C = A*B (+bias) through memory-map port B, writes C back and clears the flag.
module matvec_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ACC_WIDTH     = 80,
  parameter int POLL_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);
  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_POLL_CHK, S_CFG, S_ROW_INIT, S_ROW_CAP,
    S_RD_A, S_RD_B, S_LAST_MAC, S_WR_C, S_CLR
  } state_t;
  localparam logic [31:0] POLL_LD = POLL_INTERVAL;
  localparam logic [ADDR_WIDTH-1:0] FLAG_ADDR = ADDR_WIDTH'(12'hB00);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  state_t r_state, w_next;
  logic [31:0] r_poll;
  logic [2:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_a_base, r_b_base, r_c_base, r_bias_base, r_row_base;
  logic [15:0] r_m, r_n, r_i, r_j;
  logic [DATA_WIDTH-1:0] r_a;
  logic signed [ACC_WIDTH-1:0] r_acc, w_acc_mac;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic [ADDR_WIDTH-1:0] w_cfg_addr, w_rd_word;
  logic [DATA_WIDTH-1:0] w_sat_val;
  logic r_busy, r_done, r_sat, w_over, w_under;
  assign w_prod = $signed(r_a) * $signed(mem_rdata);
  assign w_acc_mac = r_acc + ACC_WIDTH'(w_prod);
  assign w_over = r_acc > MAXV;
  assign w_under = r_acc < MINV;
  assign w_sat_val = w_over ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                     w_under ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : r_acc[DATA_WIDTH-1:0];
  // descriptor words 0x300..0x700 step by 0x100; the bias base sits apart at 0xD00
  assign w_cfg_addr = (r_cnt == 3'd5) ? ADDR_WIDTH'(12'hD00) : ADDR_WIDTH'({r_cnt + 3'd3, 8'h00});
  assign w_rd_word = ADDR_WIDTH'(mem_rdata);
  assign busy = r_busy;
  assign done = r_done;
  assign sat = r_sat;
  always_comb begin
    w_next = r_state;
    mem_addr = '0;
    mem_wdata = '0;
    mem_we = 1'b0;
    case (r_state)
      S_IDLE: w_next = (enable && r_poll <= 32'd1) ? S_POLL : S_IDLE;
      S_POLL: begin
        mem_addr = FLAG_ADDR;
        w_next = S_POLL_CHK;
      end
      S_POLL_CHK: w_next = (mem_rdata != '0) ? S_CFG : S_IDLE;
      S_CFG: begin
        mem_addr = w_cfg_addr;
        w_next = (r_cnt != 3'd6) ? S_CFG : (r_m == 16'd0 || r_n == 16'd0) ? S_CLR : S_ROW_INIT;
      end
      S_ROW_INIT: begin
        mem_addr = r_bias_base + ADDR_WIDTH'(r_i);
        w_next = (r_bias_base != '0) ? S_ROW_CAP : S_RD_A;
      end
      S_ROW_CAP: w_next = S_RD_A;
      S_RD_A: begin
        mem_addr = r_a_base + r_row_base + ADDR_WIDTH'(r_j);
        w_next = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = r_b_base + ADDR_WIDTH'(r_j);
        w_next = (r_j == r_n - 16'd1) ? S_LAST_MAC : S_RD_A;
      end
      S_LAST_MAC: w_next = S_WR_C;
      S_WR_C: begin
        mem_addr = r_c_base + ADDR_WIDTH'(r_i);
        mem_wdata = w_sat_val;
        mem_we = 1'b1;
        w_next = (r_i == r_m - 16'd1) ? S_CLR : S_ROW_INIT;
      end
      S_CLR: begin
        mem_addr = FLAG_ADDR;
        mem_we = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_poll <= POLL_LD;
      r_cnt <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
      r_bias_base <= '0;
      r_row_base <= '0;
      r_m <= '0;
      r_n <= '0;
      r_i <= '0;
      r_j <= '0;
      r_a <= '0;
      r_acc <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (enable && r_poll > 32'd1) r_poll <= r_poll - 32'd1;
        S_POLL_CHK: begin
          if (mem_rdata != '0) begin
            r_busy <= 1'b1;
            r_sat <= 1'b0;
            r_cnt <= '0;
          end else r_poll <= POLL_LD;
        end
        S_CFG: begin
          r_cnt <= r_cnt + 3'd1;
          r_i <= '0;
          r_row_base <= '0;
          if (r_cnt == 3'd1) r_a_base <= w_rd_word;
          if (r_cnt == 3'd2) r_b_base <= w_rd_word;
          if (r_cnt == 3'd3) r_c_base <= w_rd_word;
          if (r_cnt == 3'd4) r_m <= mem_rdata[15:0];
          if (r_cnt == 3'd5) r_n <= mem_rdata[15:0];
          if (r_cnt == 3'd6) r_bias_base <= w_rd_word;
        end
        S_ROW_INIT: begin
          r_j <= '0;
          r_acc <= '0;
        end
        S_ROW_CAP: r_acc <= ACC_WIDTH'($signed(mem_rdata));
        S_RD_A: if (r_j != 16'd0) r_acc <= w_acc_mac;
        S_RD_B: begin
          r_a <= mem_rdata;
          r_j <= r_j + 16'd1;
        end
        S_LAST_MAC: r_acc <= w_acc_mac;
        S_WR_C: begin
          r_sat <= r_sat | w_over | w_under;
          r_i <= r_i + 16'd1;
          r_row_base <= r_row_base + ADDR_WIDTH'(r_n);
        end
        S_CLR: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_poll <= POLL_LD;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: directed jobs against a behavioural memory map; C writes are checked by a scoreboard monitor.
module tb_matvec_engine;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we, busy, done, sat;
  logic h_we = 1'b0, h_clr = 1'b1;
  logic [31:0] h_addr = '0, h_data = '0;
  logic [31:0] mem [0:32767];
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t q[$];
  int checks = 0, errors = 0, done_cnt = 0, busy_cyc = 0;
  always #5 clk = ~clk;
  matvec_engine #(.POLL_INTERVAL(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .done(done), .sat(sat)
  );
  always @(posedge clk) begin
    if (h_clr) for (int k = 0; k < 32768; k++) mem[k] <= '0;
    else begin
      if (mem_we) mem[mem_addr[14:0]] <= mem_wdata;
      if (h_we) mem[h_addr[14:0]] <= h_data;
    end
    mem_rdata <= mem[mem_addr[14:0]];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic hw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    h_we = 1'b1; h_addr = a; h_data = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask
  task automatic desc(input logic [31:0] m, input logic [31:0] n, input logic [31:0] bias);
    hw(32'h300, 32'h1000); hw(32'h400, 32'h2000); hw(32'h500, 32'h3000);
    hw(32'h600, m); hw(32'h700, n); hw(32'hD00, bias);
  endtask
  task automatic load_t1();
    logic [31:0] a [6] = '{1, 2, 3, 4, 5, 6};
    logic [31:0] b [3] = '{1, 32'hFFFFFFFF, 2};
    for (int k = 0; k < 6; k++) hw(32'h1000 + k, a[k]);
    for (int k = 0; k < 3; k++) hw(32'h2000 + k, b[k]);
  endtask
  task automatic wait_done(input string nm, input int d0);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
    chk({nm, "_done_seen"}, 32'(done_cnt != d0), 1);
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 1);
  endtask
  task automatic run_job(input string nm, input logic exp_sat);
    int d0;
    d0 = done_cnt;
    busy_cyc = 0;
    hw(32'hB00, 1);
    wait_done(nm, d0);
    chk({nm, "_flag"}, mem[32'hB00], 0);
    chk({nm, "_sat"}, 32'(sat), 32'(exp_sat));
    chk({nm, "_pending"}, 32'(q.size()), 0);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (done) done_cnt++;
          if (busy) busy_cyc++;
          if (mem_we) begin
            if (mem_addr == 32'hB00) chk("flag_clear_data", mem_wdata, 0);
            else if (q.size() == 0) chk("unexpected_write_addr", mem_addr, 32'hFFFFFFFF);
            else begin
              wr_t e;
              e = q.pop_front();
              chk("c_write_addr", mem_addr, e.a);
              chk("c_write_data", mem_wdata, e.d);
            end
          end
        end
      end
    join_none
    repeat (2) @(negedge clk);
    h_clr = 1'b0;
    @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sat", 32'(sat), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    // 1: plain matvec
    desc(2, 3, 0);
    load_t1();
    q.push_back('{32'h3000, 32'd5});
    q.push_back('{32'h3001, 32'd11});
    run_job("t1", 1'b0);
    chk("t1_c0", mem[32'h3000], 5);
    chk("t1_c1", mem[32'h3001], 11);
    // 2: with bias
    hw(32'h4000, 10);
    hw(32'h4001, 32'hFFFFFFEC);
    hw(32'hD00, 32'h4000);
    q.push_back('{32'h3000, 32'd15});
    q.push_back('{32'h3001, 32'hFFFFFFF7});
    run_job("t2", 1'b0);
    // 3: positive then negative saturation
    desc(1, 2, 0);
    hw(32'h1000, 32'h7FFFFFFF); hw(32'h1001, 32'h7FFFFFFF);
    hw(32'h2000, 2); hw(32'h2001, 2);
    q.push_back('{32'h3000, 32'h7FFFFFFF});
    run_job("t3_pos", 1'b1);
    hw(32'h2000, 32'hFFFFFFFE); hw(32'h2001, 32'hFFFFFFFE);
    q.push_back('{32'h3000, 32'h80000000});
    run_job("t3_neg", 1'b1);
    // 4: empty job
    desc(0, 5, 0);
    run_job("t4", 1'b0);
    chk("t4_busy_len_le_11", 32'(busy_cyc <= 11), 1);
    chk("t4_busy_len_nz", 32'(busy_cyc > 0), 1);
    // 5: reset during row-1 element loop, job reruns
    desc(2, 3, 0);
    load_t1();
    hw(32'h3000, 0); hw(32'h3001, 0);
    q.push_back('{32'h3000, 32'd5});
    q.push_back('{32'h3000, 32'd5});
    q.push_back('{32'h3001, 32'd11});
    hw(32'hB00, 1);
    begin
      int k;
      for (k = 0; k < 3000 && !(mem_we && mem_addr == 32'h3000); k++) @(negedge clk);
      chk("t5_row0_write_seen", 32'(k < 3000), 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_we", 32'(mem_we), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_flag_kept", mem[32'hB00], 1);
    rst_n = 1'b1;
    wait_done("t5", done_cnt);
    chk("t5_c0", mem[32'h3000], 5);
    chk("t5_c1", mem[32'h3001], 11);
    chk("t5_flag", mem[32'hB00], 0);
    chk("t5_sat", 32'(sat), 0);
    chk("t5_pending", 32'(q.size()), 0);
    // 6: enable gating of polls
    enable = 1'b0;
    desc(0, 5, 0);
    hw(32'hB00, 1);
    begin
      int polls, busy_seen;
      polls = 0; busy_seen = 0;
      repeat (100) begin
        @(negedge clk);
        if (mem_addr == 32'hB00) polls++;
        if (busy) busy_seen++;
      end
      chk("t6_no_poll", 32'(polls), 0);
      chk("t6_no_busy", 32'(busy_seen), 0);
    end
    begin
      int k, d0;
      logic hit;
      d0 = done_cnt;
      hit = 1'b0;
      enable = 1'b1;
      for (k = 0; k < 17 && !hit; k++) begin
        @(negedge clk);
        hit = (mem_addr == 32'hB00) && !mem_we;
      end
      chk("t6_poll_within_interval", 32'(hit), 1);
      wait_done("t6", d0);
      chk("t6_flag", mem[32'hB00], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
